// File: rtl/apb_master_bridge_if.sv
// rtl/apb_master_bridge_if.sv - command channel and APB bus signals for apb_master_bridge
interface apb_master_bridge_if #(
   parameter int APB_ADDR_WIDTH = 16,
   parameter int APB_DATA_WIDTH = 16
);
   logic                      i_cmd_valid;
   logic                      o_cmd_ready;
   logic                      i_cmd_write;
   logic [APB_ADDR_WIDTH-1:0] i_cmd_addr;
   logic [APB_DATA_WIDTH-1:0] i_cmd_wdata;
   logic                      o_psel;
   logic                      o_penable;
   logic                      o_pwrite;
   logic [APB_ADDR_WIDTH-1:0] o_paddr;
   logic [APB_DATA_WIDTH-1:0] o_pwdata;
   logic                      i_pready;
   logic [APB_DATA_WIDTH-1:0] i_prdata;
   logic                      o_rsp_valid;
   logic [APB_DATA_WIDTH-1:0] o_rsp_rdata;
   logic                      o_rsp_err;

   modport master (
      input  i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_wdata, i_pready, i_prdata,
      output o_cmd_ready, o_psel, o_penable, o_pwrite, o_paddr, o_pwdata,
             o_rsp_valid, o_rsp_rdata, o_rsp_err
   );

   modport slave (
      output i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_wdata, i_pready, i_prdata,
      input  o_cmd_ready, o_psel, o_penable, o_pwrite, o_paddr, o_pwdata,
             o_rsp_valid, o_rsp_rdata, o_rsp_err
   );
endinterface

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - single-outstanding APB requester; APB_TIMEOUT_EN enables ACCESS timeout abort
module apb_master_bridge #(
   parameter int APB_ADDR_WIDTH = 16,
   parameter int APB_DATA_WIDTH = 16,
   parameter int TIMEOUT_CYCLES = 255
) (
   input logic                 pclk,
   input logic                 preset,
   apb_master_bridge_if.master bus
);
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

   state_e                    state_q, state_d;
   logic                      pwrite_q, pwrite_d;
   logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
   logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                      err_q, err_d;
   logic                      accept, done, timeout_hit;

   assign accept = (state_q == IDLE) && bus.i_cmd_valid;
   assign done   = (state_q == ACCESS) && (bus.i_pready || timeout_hit);

`ifdef APB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == SETUP)
         cnt_d = '0;
      else if ((state_q == ACCESS) && !bus.i_pready)
         cnt_d = cnt_q + CNT_W'(1);
   end

   // This cycle's increment would reach the limit; a late pready still wins.
   assign timeout_hit = !bus.i_pready && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:   if (bus.i_cmd_valid) state_d = SETUP;
         SETUP:  state_d = ACCESS;
         ACCESS: if (done) state_d = RESP;
         RESP:   state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.o_cmd_ready = 1'b0;
      bus.o_psel      = 1'b0;
      bus.o_penable   = 1'b0;
      bus.o_rsp_valid = 1'b0;
      unique case (state_q)
         IDLE:   bus.o_cmd_ready = !preset;
         SETUP:  bus.o_psel      = 1'b1;
         ACCESS: begin
            bus.o_psel    = 1'b1;
            bus.o_penable = 1'b1;
         end
         RESP:   bus.o_rsp_valid = 1'b1;
      endcase
   end

   always_comb begin
      pwrite_d = pwrite_q;
      paddr_d  = paddr_q;
      pwdata_d = pwdata_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      if (accept) begin
         pwrite_d = bus.i_cmd_write;
         paddr_d  = bus.i_cmd_addr;
         pwdata_d = bus.i_cmd_wdata;
      end
      if (done) begin
         err_d   = timeout_hit;
         rdata_d = (pwrite_q || timeout_hit) ? '0 : bus.i_prdata;
      end
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         pwrite_q <= 1'b0;
         paddr_q  <= '0;
         pwdata_q <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         pwrite_q <= pwrite_d;
         paddr_q  <= paddr_d;
         pwdata_q <= pwdata_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   assign bus.o_pwrite    = pwrite_q;
   assign bus.o_paddr     = paddr_q;
   assign bus.o_pwdata    = pwdata_q;
   assign bus.o_rsp_rdata = rdata_q;
   assign bus.o_rsp_err   = err_q;
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - directed self-checking bench for apb_master_bridge
module tb_apb_master_bridge;
   localparam int AW = 16;
   localparam int DW = 16;
   localparam int TO = 4;

   logic pclk = 1'b0;
   logic preset;
   int   checks = 0;
   int   failures = 0;

   apb_master_bridge_if #(.APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW)) bus ();

   apb_master_bridge #(
      .APB_ADDR_WIDTH(AW),
      .APB_DATA_WIDTH(DW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .pclk   (pclk),
      .preset (preset),
      .bus    (bus)
   );

   always #5 pclk = ~pclk;

   // {psel, penable, rsp_valid, cmd_ready}
   logic [3:0] ctl;
   assign ctl = {bus.o_psel, bus.o_penable, bus.o_rsp_valid, bus.o_cmd_ready};

   task automatic tick;
      @(posedge pclk);
      #1;
   endtask

   task automatic test_reset;
      preset = 1'b1;
      #1;
      checks++; if (ctl !== 4'b0000) begin failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 4'b0000); end
      checks++; if ({bus.o_paddr, bus.o_pwdata, bus.o_pwrite, bus.o_rsp_rdata, bus.o_rsp_err} !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", {bus.o_paddr, bus.o_pwdata, bus.o_pwrite, bus.o_rsp_rdata, bus.o_rsp_err}); end
      tick();
      tick();
      preset = 1'b0;
      tick();
      checks++; if (ctl !== 4'b0001) begin failures++; $display("FAIL reset_release got=%b exp=%b", ctl, 4'b0001); end
      // start a read that stalls in ACCESS, then reset mid-cycle
      bus.i_cmd_valid = 1'b1; bus.i_cmd_write = 1'b0; bus.i_cmd_addr = 16'h0077; bus.i_pready = 1'b0;
      tick();
      bus.i_cmd_valid = 1'b0;
      tick();
      checks++; if (ctl !== 4'b1100) begin failures++; $display("FAIL reset_pre_access got=%b exp=%b", ctl, 4'b1100); end
      #2;
      preset = 1'b1;
      #1;
      checks++; if (ctl !== 4'b0000) begin failures++; $display("FAIL reset_mid_access got=%b exp=%b", ctl, 4'b0000); end
      tick();
      preset = 1'b0;
      bus.i_pready = 1'b1;
      tick();
      checks++; if (ctl !== 4'b0001) begin failures++; $display("FAIL reset_after_abort got=%b exp=%b", ctl, 4'b0001); end
      tick();
      checks++; if (ctl !== 4'b0001) begin failures++; $display("FAIL reset_no_rsp got=%b exp=%b", ctl, 4'b0001); end
   endtask

   task automatic test_read;
      bus.i_cmd_valid = 1'b1; bus.i_cmd_write = 1'b0; bus.i_cmd_addr = 16'h0001; bus.i_cmd_wdata = 16'h3C3C;
      bus.i_pready = 1'b0; bus.i_prdata = 16'hDEAD;
      tick();
      bus.i_cmd_valid = 1'b0;
      checks++; if (ctl !== 4'b1000) begin failures++; $display("FAIL read_setup got=%b exp=%b", ctl, 4'b1000); end
      checks++; if ({bus.o_pwrite, bus.o_paddr} !== {1'b0, 16'h0001}) begin failures++; $display("FAIL read_addr got=%h exp=%h", {bus.o_pwrite, bus.o_paddr}, {1'b0, 16'h0001}); end
      tick();
      checks++; if (ctl !== 4'b1100) begin failures++; $display("FAIL read_access1 got=%b exp=%b", ctl, 4'b1100); end
      tick();
      checks++; if (ctl !== 4'b1100) begin failures++; $display("FAIL read_access2 got=%b exp=%b", ctl, 4'b1100); end
      tick();
      bus.i_pready = 1'b1; bus.i_prdata = 16'h1234;
      checks++; if (ctl !== 4'b1100) begin failures++; $display("FAIL read_access3 got=%b exp=%b", ctl, 4'b1100); end
      tick();
      bus.i_pready = 1'b0; bus.i_prdata = 16'hBEEF;
      checks++; if (ctl !== 4'b0010) begin failures++; $display("FAIL read_resp got=%b exp=%b", ctl, 4'b0010); end
      checks++; if ({bus.o_rsp_rdata, bus.o_rsp_err} !== {16'h1234, 1'b0}) begin failures++; $display("FAIL read_rdata got=%h exp=%h", {bus.o_rsp_rdata, bus.o_rsp_err}, {16'h1234, 1'b0}); end
      tick();
      checks++; if (ctl !== 4'b0001) begin failures++; $display("FAIL read_idle got=%b exp=%b", ctl, 4'b0001); end
      checks++; if ({bus.o_rsp_rdata, bus.o_paddr} !== {16'h1234, 16'h0001}) begin failures++; $display("FAIL read_hold got=%h exp=%h", {bus.o_rsp_rdata, bus.o_paddr}, {16'h1234, 16'h0001}); end
   endtask

   task automatic test_write;
      bus.i_cmd_valid = 1'b1; bus.i_cmd_write = 1'b1; bus.i_cmd_addr = 16'h0000; bus.i_cmd_wdata = 16'hA5A5;
      bus.i_pready = 1'b1; bus.i_prdata = 16'hFFFF;
      tick();
      bus.i_cmd_valid = 1'b0;
      checks++; if (ctl !== 4'b1000) begin failures++; $display("FAIL write_setup got=%b exp=%b", ctl, 4'b1000); end
      checks++; if ({bus.o_pwrite, bus.o_paddr, bus.o_pwdata} !== {1'b1, 16'h0000, 16'hA5A5}) begin failures++; $display("FAIL write_bus got=%h exp=%h", {bus.o_pwrite, bus.o_paddr, bus.o_pwdata}, {1'b1, 16'h0000, 16'hA5A5}); end
      tick();
      checks++; if (ctl !== 4'b1100) begin failures++; $display("FAIL write_access got=%b exp=%b", ctl, 4'b1100); end
      tick();
      checks++; if (ctl !== 4'b0010) begin failures++; $display("FAIL write_resp got=%b exp=%b", ctl, 4'b0010); end
      checks++; if ({bus.o_rsp_rdata, bus.o_rsp_err} !== 17'h0) begin failures++; $display("FAIL write_rdata got=%h exp=0", {bus.o_rsp_rdata, bus.o_rsp_err}); end
      tick();
      checks++; if (ctl !== 4'b0001) begin failures++; $display("FAIL write_idle got=%b exp=%b", ctl, 4'b0001); end
   endtask

   task automatic test_back_to_back;
      bus.i_cmd_valid = 1'b1; bus.i_cmd_write = 1'b1; bus.i_pready = 1'b1;
      bus.i_cmd_addr = 16'h0010; bus.i_cmd_wdata = 16'h0100;
      for (int n = 0; n < 3; n++) begin
         checks++; if (ctl !== 4'b0001) begin failures++; $display("FAIL b2b_ready%0d got=%b exp=%b", n, ctl, 4'b0001); end
         tick();
         bus.i_cmd_addr = 16'h0011 + 16'(n); bus.i_cmd_wdata = 16'h0101 + 16'(n);
         checks++; if (ctl !== 4'b1000) begin failures++; $display("FAIL b2b_setup%0d got=%b exp=%b", n, ctl, 4'b1000); end
         checks++; if ({bus.o_paddr, bus.o_pwdata} !== {16'h0010 + 16'(n), 16'h0100 + 16'(n)}) begin failures++; $display("FAIL b2b_bus%0d got=%h exp=%h", n, {bus.o_paddr, bus.o_pwdata}, {16'h0010 + 16'(n), 16'h0100 + 16'(n)}); end
         tick();
         checks++; if (ctl !== 4'b1100) begin failures++; $display("FAIL b2b_access%0d got=%b exp=%b", n, ctl, 4'b1100); end
         checks++; if (bus.o_paddr !== 16'h0010 + 16'(n)) begin failures++; $display("FAIL b2b_addr_stable%0d got=%h exp=%h", n, bus.o_paddr, 16'h0010 + 16'(n)); end
         tick();
         checks++; if (ctl !== 4'b0010) begin failures++; $display("FAIL b2b_resp%0d got=%b exp=%b", n, ctl, 4'b0010); end
         if (n == 2) bus.i_cmd_valid = 1'b0;
         tick();
      end
      checks++; if (ctl !== 4'b0001) begin failures++; $display("FAIL b2b_end got=%b exp=%b", ctl, 4'b0001); end
      tick();
      checks++; if (ctl !== 4'b0001) begin failures++; $display("FAIL b2b_no_extra got=%b exp=%b", ctl, 4'b0001); end
   endtask

`ifdef APB_TIMEOUT_EN
   task automatic test_timeout;
      bus.i_cmd_valid = 1'b1; bus.i_cmd_write = 1'b0; bus.i_cmd_addr = 16'h0002;
      bus.i_pready = 1'b0; bus.i_prdata = 16'h5555;
      tick();
      bus.i_cmd_valid = 1'b0;
      tick();
      for (int k = 0; k < TO; k++) begin
         checks++; if (ctl !== 4'b1100) begin failures++; $display("FAIL timeout_access%0d got=%b exp=%b", k, ctl, 4'b1100); end
         tick();
      end
      checks++; if (ctl !== 4'b0010) begin failures++; $display("FAIL timeout_resp got=%b exp=%b", ctl, 4'b0010); end
      checks++; if ({bus.o_rsp_rdata, bus.o_rsp_err} !== {16'h0000, 1'b1}) begin failures++; $display("FAIL timeout_err got=%h exp=%h", {bus.o_rsp_rdata, bus.o_rsp_err}, {16'h0000, 1'b1}); end
      tick();
   endtask

   task automatic test_timeout_edge;
      bus.i_cmd_valid = 1'b1; bus.i_cmd_write = 1'b0; bus.i_cmd_addr = 16'h0003;
      bus.i_pready = 1'b0; bus.i_prdata = 16'h0F0F;
      tick();
      bus.i_cmd_valid = 1'b0;
      tick();
      for (int k = 0; k < TO; k++) begin
         if (k == TO - 1) bus.i_pready = 1'b1;
         checks++; if (ctl !== 4'b1100) begin failures++; $display("FAIL edge_access%0d got=%b exp=%b", k, ctl, 4'b1100); end
         tick();
      end
      bus.i_pready = 1'b0;
      checks++; if (ctl !== 4'b0010) begin failures++; $display("FAIL edge_resp got=%b exp=%b", ctl, 4'b0010); end
      checks++; if ({bus.o_rsp_rdata, bus.o_rsp_err} !== {16'h0F0F, 1'b0}) begin failures++; $display("FAIL edge_rdata got=%h exp=%h", {bus.o_rsp_rdata, bus.o_rsp_err}, {16'h0F0F, 1'b0}); end
      tick();
   endtask
`endif

   initial begin
      bus.i_cmd_valid = 1'b0;
      bus.i_cmd_write = 1'b0;
      bus.i_cmd_addr  = '0;
      bus.i_cmd_wdata = '0;
      bus.i_pready    = 1'b0;
      bus.i_prdata    = '0;
      test_reset();
      test_read();
`ifdef APB_TIMEOUT_EN
      test_timeout();
`endif
      test_write();
      test_back_to_back();
`ifdef APB_TIMEOUT_EN
      test_timeout_edge();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
